// File: rtl/vector_logic_gate.sv
// Element-serial bitwise logic unit: streams SIZE_IN operand pairs through an opcode-selected gate.
// Optional macro VECTOR_LOGIC_GATE_REDUCE_EN adds DATA_REDUCE_OUT, the XOR fold of all emitted results.
module vector_logic_gate #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic [2:0]              OPCODE_IN,
  input  logic [CONTROL_SIZE-1:0] SIZE_IN,
  input  logic                    DATA_A_IN_ENABLE,
  input  logic                    DATA_B_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]    DATA_A_IN,
  input  logic [DATA_SIZE-1:0]    DATA_B_IN,
  output logic                    DATA_OUT_ENABLE,
  output logic [DATA_SIZE-1:0]    DATA_OUT
`ifdef VECTOR_LOGIC_GATE_REDUCE_EN
  ,
  output logic [DATA_SIZE-1:0]    DATA_REDUCE_OUT
`endif
);

  typedef enum logic {S_IDLE, S_INPUT} state_e;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOTA = 3'b110,
    OP_PASA = 3'b111
  } opcode_e;

  state_e                  state_q, state_d;
  opcode_e                 opcode_q;
  logic [CONTROL_SIZE-1:0] size_q;
  logic [CONTROL_SIZE-1:0] count_q;
  logic                    a_flag_q, b_flag_q;
  logic [DATA_SIZE-1:0]    a_q, b_q;

  logic                    a_present, b_present;
  logic [DATA_SIZE-1:0]    a_val, b_val, result;
  logic                    elem_done, last_elem, op_done;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    a_val     = DATA_A_IN_ENABLE ? DATA_A_IN : a_q;
    b_val     = DATA_B_IN_ENABLE ? DATA_B_IN : b_q;
    result    = a_val;
    a_present = a_flag_q | DATA_A_IN_ENABLE;
    // Unary opcodes (NOT A, pass A) never wait for B.
    b_present = b_flag_q | DATA_B_IN_ENABLE | (opcode_q == OP_NOTA) | (opcode_q == OP_PASA);

    unique case (opcode_q)
      OP_AND:  result = a_val & b_val;
      OP_OR:   result = a_val | b_val;
      OP_XOR:  result = a_val ^ b_val;
      OP_NAND: result = ~(a_val & b_val);
      OP_NOR:  result = ~(a_val | b_val);
      OP_XNOR: result = ~(a_val ^ b_val);
      OP_NOTA: result = ~a_val;
      OP_PASA: result = a_val;
      default: result = a_val;
    endcase

    elem_done = (state_q == S_INPUT) && (size_q != '0) && a_present && b_present;
    last_elem = (count_q == size_q - CONTROL_SIZE'(1));
    op_done   = (state_q == S_INPUT) && ((size_q == '0) || (elem_done && last_elem));

    unique case (state_q)
      S_IDLE:  if (START)   state_d = S_INPUT;
      S_INPUT: if (op_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q         <= S_IDLE;
      opcode_q        <= OP_AND;
      size_q          <= '0;
      count_q         <= '0;
      a_flag_q        <= 1'b0;
      b_flag_q        <= 1'b0;
      a_q             <= '0;
      b_q             <= '0;
      READY           <= 1'b0;
      DATA_OUT_ENABLE <= 1'b0;
      DATA_OUT        <= '0;
    end else begin
      state_q         <= state_d;
      READY           <= op_done;
      DATA_OUT_ENABLE <= elem_done;
      if (state_q == S_IDLE) begin
        if (START) begin
          opcode_q <= opcode_e'(OPCODE_IN);
          size_q   <= SIZE_IN;
          count_q  <= '0;
          a_flag_q <= 1'b0;
          b_flag_q <= 1'b0;
        end
      end else if (elem_done) begin
        DATA_OUT <= result;
        count_q  <= count_q + CONTROL_SIZE'(1);
        a_flag_q <= 1'b0;
        b_flag_q <= 1'b0;
      end else begin
        // A repeated enable simply overwrites the held operand.
        if (DATA_A_IN_ENABLE) begin
          a_q      <= DATA_A_IN;
          a_flag_q <= 1'b1;
        end
        if (DATA_B_IN_ENABLE) begin
          b_q      <= DATA_B_IN;
          b_flag_q <= 1'b1;
        end
      end
    end
  end

`ifdef VECTOR_LOGIC_GATE_REDUCE_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DATA_REDUCE_OUT <= '0;
    end else if (state_q == S_IDLE && START) begin
      DATA_REDUCE_OUT <= '0;
    end else if (elem_done) begin
      DATA_REDUCE_OUT <= DATA_REDUCE_OUT ^ result;
    end
  end
`endif

endmodule

// File: tb/tb_vector_logic_gate.sv
// Directed self-checking bench for vector_logic_gate (DATA_SIZE=8); covers the reduce output when its macro is set.
module tb_vector_logic_gate;

  localparam int DW = 8;
  localparam int CW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic          READY;
  logic [2:0]    OPCODE_IN;
  logic [CW-1:0] SIZE_IN;
  logic          DATA_A_IN_ENABLE, DATA_B_IN_ENABLE;
  logic [DW-1:0] DATA_A_IN, DATA_B_IN;
  logic          DATA_OUT_ENABLE;
  logic [DW-1:0] DATA_OUT;
`ifdef VECTOR_LOGIC_GATE_REDUCE_EN
  logic [DW-1:0] DATA_REDUCE_OUT;
`endif

  int checks = 0;
  int errors = 0;

  vector_logic_gate #(.DATA_SIZE(DW), .CONTROL_SIZE(CW)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .START            (START),
    .READY            (READY),
    .OPCODE_IN        (OPCODE_IN),
    .SIZE_IN          (SIZE_IN),
    .DATA_A_IN_ENABLE (DATA_A_IN_ENABLE),
    .DATA_B_IN_ENABLE (DATA_B_IN_ENABLE),
    .DATA_A_IN        (DATA_A_IN),
    .DATA_B_IN        (DATA_B_IN),
    .DATA_OUT_ENABLE  (DATA_OUT_ENABLE),
    .DATA_OUT         (DATA_OUT)
`ifdef VECTOR_LOGIC_GATE_REDUCE_EN
    ,
    .DATA_REDUCE_OUT  (DATA_REDUCE_OUT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_op(input logic [2:0] op, input logic [CW-1:0] n);
    START     = 1'b1;
    OPCODE_IN = op;
    SIZE_IN   = n;
    step();
    START     = 1'b0;
  endtask

  task automatic drive(input logic ae, input logic [DW-1:0] a, input logic be, input logic [DW-1:0] b);
    DATA_A_IN_ENABLE = ae;
    DATA_A_IN        = a;
    DATA_B_IN_ENABLE = be;
    DATA_B_IN        = b;
  endtask

  initial begin
    logic [DW-1:0] a3 [3];
    logic [DW-1:0] b3 [3];
    logic [DW-1:0] and3 [3];
    a3   = '{8'hFF, 8'h0F, 8'hAA};
    b3   = '{8'h11, 8'hF0, 8'hAA};
    and3 = '{8'h11, 8'h00, 8'hAA};

    RST = 1'b1;
    START = 1'b0;
    OPCODE_IN = '0;
    SIZE_IN = '0;
    drive(1'b0, '0, 1'b0, '0);
    step();
    step();
    check("reset_ready", READY, 0);
    check("reset_doe", DATA_OUT_ENABLE, 0);
    check("reset_dout", DATA_OUT, 0);
`ifdef VECTOR_LOGIC_GATE_REDUCE_EN
    check("reset_reduce", DATA_REDUCE_OUT, 0);
`endif
    RST = 1'b0;
    step();

    // XNOR, one element, both operands in the same cycle.
    start_op(3'b101, 1);
    drive(1'b1, 8'hF0, 1'b1, 8'hCC);
    check("xnor_pre_doe", DATA_OUT_ENABLE, 0);
    step();
    drive(1'b0, '0, 1'b0, '0);
    check("xnor_dout", DATA_OUT, 8'hC3);
    check("xnor_doe", DATA_OUT_ENABLE, 1);
    check("xnor_ready", READY, 1);
    step();
    check("xnor_doe_drop", DATA_OUT_ENABLE, 0);
    check("xnor_ready_drop", READY, 0);
    check("xnor_hold", DATA_OUT, 8'hC3);

    // AND, three elements, B two cycles after A.
    start_op(3'b000, 3);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, a3[i], 1'b0, '0);
      step();
      drive(1'b0, '0, 1'b0, '0);
      step();
      check("and_wait_b", DATA_OUT_ENABLE, 0);
      drive(1'b0, '0, 1'b1, b3[i]);
      step();
      drive(1'b0, '0, 1'b0, '0);
      check("and_dout", DATA_OUT, and3[i]);
      check("and_doe", DATA_OUT_ENABLE, 1);
      check("and_ready", READY, (i == 2) ? 1 : 0);
    end
    step();
    check("and_ready_drop", READY, 0);

    // NOT A, B never enabled.
    start_op(3'b110, 2);
    drive(1'b1, 8'h00, 1'b0, '0);
    step();
    check("nota_dout0", DATA_OUT, 8'hFF);
    check("nota_ready0", READY, 0);
    drive(1'b1, 8'h5A, 1'b0, '0);
    step();
    drive(1'b0, '0, 1'b0, '0);
    check("nota_dout1", DATA_OUT, 8'hA5);
    check("nota_doe1", DATA_OUT_ENABLE, 1);
    check("nota_ready1", READY, 1);

    // OR with a repeated A enable: the later value replaces the first.
    start_op(3'b001, 1);
    drive(1'b1, 8'h01, 1'b0, '0);
    step();
    drive(1'b1, 8'h80, 1'b0, '0);
    step();
    check("or_no_early", DATA_OUT_ENABLE, 0);
    drive(1'b0, '0, 1'b1, 8'h02);
    step();
    drive(1'b0, '0, 1'b0, '0);
    check("or_overwrite", DATA_OUT, 8'h82);

    // Zero-length operation.
    start_op(3'b010, 0);
    check("size0_ready_early", READY, 0);
    step();
    check("size0_ready", READY, 1);
    check("size0_no_doe", DATA_OUT_ENABLE, 0);
    step();
    check("size0_ready_drop", READY, 0);

    // START during INPUT is ignored: opcode and count are unaffected.
    start_op(3'b010, 2);
    drive(1'b1, 8'h0F, 1'b1, 8'hF0);
    step();
    drive(1'b0, '0, 1'b0, '0);
    check("xor_dout0", DATA_OUT, 8'hFF);
    check("xor_ready0", READY, 0);
    START = 1'b1;
    OPCODE_IN = 3'b000;
    SIZE_IN = 1;
    step();
    START = 1'b0;
    drive(1'b1, 8'h33, 1'b1, 8'h11);
    step();
    drive(1'b0, '0, 1'b0, '0);
    check("xor_dout1", DATA_OUT, 8'h22);
    check("xor_ready1", READY, 1);

    // Reset mid-operation, with a held A operand pending.
    start_op(3'b000, 4);
    drive(1'b1, 8'h3C, 1'b1, 8'hFF);
    step();
    check("rst_pre_dout", DATA_OUT, 8'h3C);
    drive(1'b1, 8'h55, 1'b0, '0);
    step();
    drive(1'b0, '0, 1'b0, '0);
    #2 RST = 1'b1;
    #1;
    check("rst_async_dout", DATA_OUT, 0);
    check("rst_async_doe", DATA_OUT_ENABLE, 0);
    check("rst_async_ready", READY, 0);
    step();
    RST = 1'b0;
    step();
    start_op(3'b000, 1);
    drive(1'b0, '0, 1'b1, 8'hFF);
    step();
    check("rst_no_residue", DATA_OUT_ENABLE, 0);
    drive(1'b1, 8'h81, 1'b0, '0);
    step();
    drive(1'b0, '0, 1'b0, '0);
    check("rst_fresh_dout", DATA_OUT, 8'h81);
    check("rst_fresh_ready", READY, 1);

`ifdef VECTOR_LOGIC_GATE_REDUCE_EN
    // Pass A over three elements; reduce is the XOR of all outputs.
    start_op(3'b111, 3);
    drive(1'b1, 8'h01, 1'b0, '0);
    step();
    drive(1'b1, 8'h02, 1'b0, '0);
    step();
    drive(1'b1, 8'h04, 1'b0, '0);
    step();
    drive(1'b0, '0, 1'b0, '0);
    check("reduce_ready", READY, 1);
    check("reduce_value", DATA_REDUCE_OUT, 8'h07);
    step();
    check("reduce_hold", DATA_REDUCE_OUT, 8'h07);
`endif

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_logic_gate.md
VECTOR_LOGIC_GATE -- requirements
Module: vector_logic_gate

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 64, giving the element width in bits.
REQ-002 The block SHALL have parameter CONTROL_SIZE, default 64, giving the width of the element count and counter.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port START, input, 1 bit: operation request, sampled in IDLE only.
REQ-006 The block SHALL have port READY, output, 1 bit: one-cycle pulse marking operation completion.
REQ-007 The block SHALL have port OPCODE_IN, input, 3 bits: selects the logic function, latched at START.
REQ-008 The block SHALL have port SIZE_IN, input, CONTROL_SIZE bits: element count, latched at START.
REQ-009 The block SHALL have port DATA_A_IN_ENABLE, input, 1 bit: DATA_A_IN valid this cycle.
REQ-010 The block SHALL have port DATA_B_IN_ENABLE, input, 1 bit: DATA_B_IN valid this cycle.
REQ-011 The block SHALL have port DATA_A_IN, input, DATA_SIZE bits: operand A element.
REQ-012 The block SHALL have port DATA_B_IN, input, DATA_SIZE bits: operand B element.
REQ-013 The block SHALL have port DATA_OUT_ENABLE, output, 1 bit: DATA_OUT valid this cycle.
REQ-014 The block SHALL have port DATA_OUT, output, DATA_SIZE bits: result element.

Function
REQ-015 The block SHALL decode OPCODE_IN as: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT A, 111 pass A; all operations bitwise.
REQ-016 The block SHALL implement a state machine with states IDLE and INPUT.
REQ-017 In IDLE, START=1 SHALL latch OPCODE_IN and SIZE_IN, clear the element counter and operand flags, and enter INPUT at the next edge.
REQ-018 START SHALL be ignored outside IDLE, and operand enables SHALL be ignored in IDLE.
REQ-019 In INPUT, an operand enable SHALL capture its operand and set its flag; a repeated enable before the element completes SHALL overwrite the held value.
REQ-020 An element SHALL complete at the edge where A is present (flag set or enable high) and, for opcodes 000-101, B is also present; for opcodes 110 and 111, B SHALL NOT be required.
REQ-021 When an operand's enable and completion occur in the same cycle, the live input SHALL be used, not the held value.
REQ-022 On completion, DATA_OUT SHALL register the result and DATA_OUT_ENABLE SHALL be high for exactly one cycle (latency: one cycle after the last required enable); flags clear and the counter increments.
REQ-023 When the completing element is number SIZE_IN-1, READY SHALL pulse in the same cycle as that DATA_OUT_ENABLE and the state SHALL return to IDLE.
REQ-024 SIZE_IN=0 SHALL produce no DATA_OUT_ENABLE, a READY pulse one cycle after the START edge, and a return to IDLE.
REQ-025 DATA_OUT SHALL hold its last value while DATA_OUT_ENABLE is low.

Reset
REQ-026 Asserting RST SHALL immediately force IDLE and zero READY, DATA_OUT_ENABLE, DATA_OUT, the counter, the flags and the latched opcode and size, including mid-operation.
REQ-027 After RST deasserts, the first START SHALL begin a fresh operation with no residue from the aborted one.

Configuration
REQ-028 With macro VECTOR_LOGIC_GATE_REDUCE_EN defined, the block SHALL add output DATA_REDUCE_OUT (DATA_SIZE bits): cleared at START and on reset, XOR-accumulating every emitted DATA_OUT, with its final value valid in the READY cycle and held until the next START.
REQ-029 Without VECTOR_LOGIC_GATE_REDUCE_EN defined, the DATA_REDUCE_OUT port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (DATA_SIZE=8)
REQ-030 OPCODE 101, SIZE 1, A=0xF0 and B=0xCC enabled in the same cycle -> DATA_OUT=0xC3, DATA_OUT_ENABLE and READY both high for one cycle, exactly one cycle later.
REQ-031 OPCODE 000, SIZE 3, with B arriving 2 cycles after A per element, A={0xFF,0x0F,0xAA}, B={0x11,0xF0,0xAA} -> outputs 0x11, 0x00, 0xAA; READY only with the third.
REQ-032 OPCODE 110, SIZE 2, A={0x00,0x5A}, B never enabled -> outputs 0xFF, 0xA5, then READY.
REQ-033 SIZE 0 -> READY one cycle after START with no DATA_OUT_ENABLE; a START asserted mid-operation is ignored and the element count is unchanged.
REQ-034 RST asserted after 1 of 4 elements -> outputs zero asynchronously; a new START with SIZE 1 completes normally.
REQ-035 With REDUCE_EN, OPCODE 111, SIZE 3, A={0x01,0x02,0x04} -> DATA_REDUCE_OUT=0x07 at READY.
